// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer and its
// downstream 4-bit register stage.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_e;

endpackage : sipo_pkg

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output bundle of the deserializer.
// The master drives the serial side; the slave is the deserializer.
interface sipo_deserializer_if
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
);

    logic             din;
    logic             din_valid;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;
    logic             frame_err;

    modport master (
        output din,
        output din_valid,
        output start,
        input  q,
        input  q_valid,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  start,
        output q,
        output q_valid,
        output busy,
        output frame_err
    );

endinterface : sipo_deserializer_if

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter. word_c is the register contents after the
// current din is shifted in, so the caller can capture a finished word at the
// same edge that samples its last bit.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_first,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] word_c,
    output logic             cnt_done_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] first_c;

    // Bit ordering: MSB-first shifts left, LSB-first shifts right.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign word_c  = {sr[WIDTH-2:0], din};
            assign first_c = {{(WIDTH-1){1'b0}}, din};
        end else begin : g_lsb_first
            assign word_c  = {din, sr[WIDTH-1:1]};
            assign first_c = {din, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // High when the bit being shifted now is the last one of the word.
    assign cnt_done_c = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load_first) begin
            sr  <= first_c;
            cnt <= CNT_W'(1);
        end else if (shift_en) begin
            sr  <= word_c;
            cnt <= cnt_done_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : sipo_shift_core

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer: frames WIDTH valid bits behind a start
// marker and presents the word on q with a one-cycle q_valid strobe.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    sipo_deserializer_if.slave  bus
);

    sipo_state_e      state_q;
    sipo_state_e      state_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             q_valid_q;
    logic             q_valid_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             busy_q;
    logic             busy_d;

    logic             shift_en;
    logic             load_first;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_c;
    logic             cnt_done_c;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk        (clk),
        .clear      (rst),
        .load_first (load_first),
        .shift_en   (shift_en),
        .din        (bus.din),
        .sr         (sr),
        .word_c     (word_c),
        .cnt_done_c (cnt_done_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        q_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        shift_en    = 1'b0;
        load_first  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.din_valid && bus.start) begin
                    load_first = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.din_valid) begin
                    if (bus.start) begin
                        // Restart: drop the partial word, this bit opens a new frame.
                        load_first  = 1'b1;
                        frame_err_d = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (cnt_done_c) begin
                            q_d       = word_c;
                            q_valid_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule : sipo_deserializer
